la_clbk: RTL

// - Generic K-input logic block: N BLEs (K-LUT plus flop) behind a full input/feedback crossbar.
// - Configuration is not on parallel ports. It is loaded serially into an internal config register

---
 rtl/la_clbk.sv | 136 +++++++++++++
 1 files changed

// File: rtl/la_clbk.sv
// la_clbk: generic K-input logic block. N BLEs (K-LUT plus flop) behind a full
// input/feedback crossbar, configured through a serial valid/ready word stream.
//
// Config handshake: a word transfers on any rising clk edge where cfg_valid and
// cfg_ready are both high. cfg_ready is high in IDLE and LOAD and low in RUN.
// cfg_data is only sampled on a transfer, and cfg_valid may be asserted at any time.
module la_clbk #(
  parameter int N = 2,
  parameter int K = 4,
  parameter int I = 8,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic [I-1:0] in,
  output logic [N-1:0] out,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_data,
  input  logic         cfg_clear,
  output logic         cfg_done
);

  localparam int SI   = $clog2(I);
  localparam int SF   = (N > 1) ? $clog2(N) : 1;
  localparam int LS   = 2**K;
  localparam int B    = LS + 1 + K * (SI + SF + 1);
  localparam int CBW  = N * B;
  localparam int C    = (CBW + W - 1) / W;
  localparam int CNTW = $clog2(C + 1);

  // Field offsets inside the configuration vector, from bit 0 upward.
  localparam int LUT_OFF = 0;
  localparam int BP_OFF  = LUT_OFF + N * LS;
  localparam int IN_OFF  = BP_OFF + N;
  localparam int FB_OFF  = IN_OFF + N * K * SI;
  localparam int LOC_OFF = FB_OFF + N * K * SF;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t          state, state_next;
  logic [CNTW-1:0] cnt, cnt_next;
  // Only the low CBW bits of the shift chain are kept; the padding bits that
  // would sit above them are never read, so they are simply shifted out.
  logic [CBW-1:0]  cfgreg;
  logic [N-1:0]    q;
  logic [N-1:0]    lut_v;
  logic            hs;
  logic            run;

  assign run      = (state == RUN);
  assign cfg_done = run;
  assign hs       = cfg_valid & cfg_ready;

  // Load FSM next-state and handshake ready.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cfg_ready  = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          cnt_next   = CNTW'(1);
          state_next = (C == 1) ? RUN : LOAD;
        end
      end
      LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          cnt_next = cnt + 1'b1;
          if (cnt == CNTW'(C - 1)) state_next = RUN;
        end
      end
      RUN: begin
        cfg_ready = 1'b0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State, word count and BLE flops; reset beats clear, clear beats a transfer.
  always_ff @(posedge clk) begin
    if (reset || cfg_clear) begin
      state <= IDLE;
      cnt   <= '0;
      q     <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (run && ce) q <= lut_v;
    end
  end

  // Config shift chain: first word ends up at the top. Contents are
  // don't-care until a full load completes, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!reset && !cfg_clear && hs) cfgreg <= (cfgreg << W) | CBW'(cfg_data);
  end

  for (genvar g = 0; g < N; g++) begin : g_ble
    logic [K-1:0]  lutin;
    logic [N-1:0]  fbv;
    logic [LS-1:0] lut_bits;

    // Feedback view of BLE g: its own flop instead of its own output, so a BLE
    // can never form a combinational loop with itself.
    always_comb begin
      for (int j = 0; j < N; j++) fbv[j] = (j == g) ? q[j] : out[j];
    end

    // Per-input crossbar: primary input or feedback, out-of-range selects give 0.
    always_comb begin
      logic [SI-1:0] isel;
      logic [SF-1:0] fsel;
      lutin = '0;
      for (int j = 0; j < K; j++) begin
        isel = cfgreg[IN_OFF + (g * K + j) * SI +: SI];
        fsel = cfgreg[FB_OFF + (g * K + j) * SF +: SF];
        if (cfgreg[LOC_OFF + g * K + j])
          lutin[j] = (int'(fsel) < N) ? fbv[fsel] : 1'b0;
        else
          lutin[j] = (int'(isel) < I) ? in[isel] : 1'b0;
      end
    end

    assign lut_bits = cfgreg[LUT_OFF + g * LS +: LS];
    assign lut_v[g] = lut_bits[lutin];
    assign out[g]   = run ? (cfgreg[BP_OFF + g] ? lut_v[g] : q[g]) : 1'b0;
  end

endmodule
